// File: rtl/ring_arb_pkg.sv
// Shared types and default constants for the ring-token round-robin arbiter.
package ring_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

endpackage : ring_arb_pkg

// File: rtl/ring_ptr.sv
// One-hot priority token. On advance it loads the releasing owner rotated
// left by one, so the token lands just past whoever gave up the resource.
module ring_ptr
  import ring_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic [N-1:0] owner_i,
  output logic [N-1:0] ptr_o
);

  logic [N-1:0] ptr_q;

  // NOTE: sequential state is written only with <= so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= N'(1);
    end else if (adv_i) begin
      ptr_q <= {owner_i[N-2:0], owner_i[N-1]};
    end
  end

  assign ptr_o = ptr_q;

endmodule : ring_ptr

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot token pointer and registered grant.
// Define RR_TIMEOUT_EN to force release after MAX_HOLD busy cycles.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  ptr
);

  if (N < 2)        begin : g_bad_n    $error("ring_rr_arbiter: N must be at least 2"); end
  if (MAX_HOLD < 1) begin : g_bad_hold $error("ring_rr_arbiter: MAX_HOLD must be at least 1"); end

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          adv;
  logic          release_req;
  logic [IW-1:0] ptr_pos;
  logic [IW-1:0] win_idx;

  ring_ptr #(.N(N)) u_ring_ptr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (adv),
    .owner_i (gnt_q),
    .ptr_o   (ptr)
  );

  // Scan from the token position upward with wrap; the nearest set request wins.
  always_comb begin
    ptr_pos = '0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) ptr_pos = IW'(i);
    end
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_pos) + k;
      if (j >= N) j = j - N;
      if (req[j]) win_idx = IW'(j);
    end
  end

`ifdef RR_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;

  assign release_req = ~|(req & gnt_q) || (hold_q == HW'(MAX_HOLD));
`else
  assign release_req = ~|(req & gnt_q);
`endif

  // NOTE: every variable driven here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    adv     = 1'b0;
`ifdef RR_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = N'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          state_d = BUSY;
`ifdef RR_TIMEOUT_EN
          hold_d  = HW'(1);
`endif
        end
      end
      BUSY: begin
        if (release_req) begin
          gnt_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          adv     = 1'b1;
          state_d = IDLE;
`ifdef RR_TIMEOUT_EN
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef RR_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef RR_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule : ring_rr_arbiter

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter (N=4, MAX_HOLD=4); expected
// grant/pointer values are queued per cycle and popped after each edge.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] ptr;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] ptr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ring_rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Queue the expected post-edge values, then drive req and advance one edge.
  task automatic push_tick(input logic [3:0] r, input logic [3:0] g, input logic [3:0] p);
    exp_t e;
    e.gnt = g;
    e.ptr = p;
    exp_q.push_back(e);
    req = r;
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] FR_REQ [16] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101,
                                         4'b1111, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111,
                                         4'b1111, 4'b1111, 4'b1110, 4'b0000};
  localparam logic [3:0] FR_GNT [16] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                         4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                         4'b0001, 4'b0001, 4'b0000, 4'b0000};
  localparam logic [3:0] FR_PTR [16] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                                         4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001,
                                         4'b0001, 4'b0001, 4'b0010, 4'b0010};

  localparam logic [3:0] WR_REQ [7] = '{4'b0100, 4'b0000, 4'b0011, 4'b0010, 4'b0011, 4'b0001, 4'b0000};
  localparam logic [3:0] WR_GNT [7] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
  localparam logic [3:0] WR_PTR [7] = '{4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0100, 4'b0100};

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    #2;
    checks++;
    if ({gnt, ptr, gnt_valid, gnt_idx} !== {4'b0000, 4'b0001, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=0000 ptr=0001 valid=0 idx=0",
               gnt, ptr, gnt_valid, gnt_idx);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({gnt, ptr, gnt_valid} !== {4'b0000, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b ptr=%b valid=%b, want gnt=0000 ptr=0001 valid=0",
               gnt, ptr, gnt_valid);
    end
  endtask

  task automatic test_single();
    logic [3:0] r [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic [3:0] g [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic [3:0] p [3] = '{4'b0001, 4'b1000, 4'b1000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      push_tick(r[i], g[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
        errors++;
        $display("FAIL single[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=%b idx=%0d",
                 i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, |e.gnt, enc(e.gnt));
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    push_tick(4'b0010, 4'b0010, 4'b1000);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
      errors++;
      $display("FAIL pre_reset_grant: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=1 idx=%0d",
               gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, enc(e.gnt));
    end
    req = 4'b0000;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, ptr, gnt_valid, gnt_idx} !== {4'b0000, 4'b0001, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=0000 ptr=0001 valid=0 idx=0",
               gnt, ptr, gnt_valid, gnt_idx);
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      push_tick(FR_REQ[i], FR_GNT[i], FR_PTR[i]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
        errors++;
        $display("FAIL fairness[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=%b idx=%0d",
                 i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, |e.gnt, enc(e.gnt));
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      push_tick(WR_REQ[i], WR_GNT[i], WR_PTR[i]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
        errors++;
        $display("FAIL wrap[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=%b idx=%0d",
                 i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, |e.gnt, enc(e.gnt));
      end
    end
  endtask

  // Requester drops in the very cycle its grant appears: one-cycle grant.
  task automatic test_early_drop();
    logic [3:0] r [2] = '{4'b0001, 4'b0000};
    logic [3:0] g [2] = '{4'b0001, 4'b0000};
    logic [3:0] p [2] = '{4'b0100, 4'b0010};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      push_tick(r[i], g[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
        errors++;
        $display("FAIL early_drop[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=%b idx=%0d",
                 i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, |e.gnt, enc(e.gnt));
      end
    end
  endtask

`ifndef RR_TIMEOUT_EN
  task automatic test_no_preempt();
    exp_t e;
    push_tick(4'b1000, 4'b1000, 4'b0010);
    push_tick(4'b0000, 4'b0000, 4'b0001);
    push_tick(4'b1111, 4'b0001, 4'b0001);
    for (int i = 0; i < 10; i++) push_tick(4'b1111, 4'b0001, 4'b0001);
    push_tick(4'b1110, 4'b0000, 4'b0010);
    // All cycles were queued up front; only the final state remains to
    // compare here, so drain and compare the tail entry explicitly.
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    e = exp_q.pop_front();
    checks++;
    if ({gnt, ptr, gnt_valid} !== {e.gnt, e.ptr, |e.gnt}) begin
      errors++;
      $display("FAIL no_preempt_release: gnt=%b ptr=%b valid=%b, want gnt=%b ptr=%b valid=%b",
               gnt, ptr, gnt_valid, e.gnt, e.ptr, |e.gnt);
    end
    req = 4'b0000;
  endtask

  task automatic test_hold();
    exp_t e;
    push_tick(4'b0000, 4'b0000, 4'b0010);
    e = exp_q.pop_front();
    push_tick(4'b0001, 4'b0001, 4'b0010);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, ptr} !== {e.gnt, e.ptr}) begin
      errors++;
      $display("FAIL hold_grant: gnt=%b ptr=%b, want gnt=%b ptr=%b", gnt, ptr, e.gnt, e.ptr);
    end
    for (int i = 0; i < 10; i++) begin
      push_tick(4'b1111, 4'b0001, 4'b0010);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
        errors++;
        $display("FAIL no_preempt[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=1 idx=%0d",
                 i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, enc(e.gnt));
      end
    end
    push_tick(4'b1110, 4'b0000, 4'b0010);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, ptr, gnt_valid} !== {e.gnt, e.ptr, 1'b0}) begin
      errors++;
      $display("FAIL hold_release: gnt=%b ptr=%b valid=%b, want gnt=%b ptr=%b valid=0",
               gnt, ptr, gnt_valid, e.gnt, e.ptr);
    end
    req = 4'b0000;
  endtask
`else
  task automatic test_timeout();
    logic [3:0] g [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    logic [3:0] p [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    exp_t e;
    req = 4'b0000;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      push_tick(4'b0011, g[i], p[i]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
        errors++;
        $display("FAIL timeout[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=%b idx=%0d",
                 i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, |e.gnt, enc(e.gnt));
      end
    end
    req = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_fairness();
    test_wrap();
    test_early_drop();
`ifndef RR_TIMEOUT_EN
    // From ptr=0010: grant/release owner 3 to move the token to 0001,
    // then owner 0 holds against a full request vector.
    begin
      exp_t e;
      push_tick(4'b1000, 4'b1000, 4'b0010);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr} !== {e.gnt, e.ptr}) begin
        errors++;
        $display("FAIL preempt_setup: gnt=%b ptr=%b, want gnt=%b ptr=%b", gnt, ptr, e.gnt, e.ptr);
      end
      push_tick(4'b0000, 4'b0000, 4'b0001);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr} !== {e.gnt, e.ptr}) begin
        errors++;
        $display("FAIL preempt_token: gnt=%b ptr=%b, want gnt=%b ptr=%b", gnt, ptr, e.gnt, e.ptr);
      end
      push_tick(4'b1111, 4'b0001, 4'b0001);
      e = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
        push_tick(4'b1111, 4'b0001, 4'b0001);
        e = exp_q.pop_front();
        checks++;
        if ({gnt, ptr, gnt_valid, gnt_idx} !== {e.gnt, e.ptr, |e.gnt, enc(e.gnt)}) begin
          errors++;
          $display("FAIL no_preempt[%0d]: gnt=%b ptr=%b valid=%b idx=%0d, want gnt=%b ptr=%b valid=1 idx=%0d",
                   i, gnt, ptr, gnt_valid, gnt_idx, e.gnt, e.ptr, enc(e.gnt));
        end
      end
      push_tick(4'b1110, 4'b0000, 4'b0010);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, ptr, gnt_valid} !== {e.gnt, e.ptr, 1'b0}) begin
        errors++;
        $display("FAIL no_preempt_release: gnt=%b ptr=%b valid=%b, want gnt=%b ptr=%b valid=0",
                 gnt, ptr, gnt_valid, e.gnt, e.ptr);
      end
      req = 4'b0000;
    end
`else
    test_timeout();
`endif
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_ring_rr_arbiter

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource between N requesters.
- Priority is tracked by a one-hot ring-counter token pointer. The pointer rotates past each owner when that owner releases, so every requester is served in fixed circular order.
- Sits in front of any shared datapath (bus, counter, ALU) as its access scheduler.
- One registered one-hot grant per cycle.

Parameters:
- N, 4, number of requesters (at least 2).
- MAX_HOLD, 8, maximum grant length in cycles. Used only when RR_TIMEOUT_EN is defined.
- IW, $clog2(N), width of gnt_idx (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i high = requester i wants or holds the resource.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  high when any gnt bit is set.
- gnt_idx  output  IW  binary index of the granted requester; 0 when idle.
- ptr  output  N  current one-hot priority token.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0.
  - ptr=one-hot bit 0 (0001 for N=4).
  - Hold counter=0.
  - If reset is asserted mid-grant, outputs clear immediately, without waiting for a clock edge.
- States: IDLE, BUSY.
- IDLE:
  - If req==0: stay in IDLE.
  - Else: choose the first set req bit, searching upward from the ptr bit position (inclusive) with wrap from N-1 to 0.
  - Register that choice as gnt at the next edge and go to BUSY.
  - Grant latency: 1 cycle from req seen in IDLE.
- BUSY:
  - Hold gnt while req[owner]=1. Other requests are ignored; there is no preemption.
  - When req[owner]=0 at an edge: gnt<=0, ptr<=owner one-hot rotated left by 1 (bit N-1 wraps to bit 0), state<=IDLE.
- Bubble: exactly one idle cycle (gnt=0) between consecutive grants.
- Pointer movement: ptr changes only on release. It stays one-hot at all times.
- Simultaneous requests: resolved purely by ptr order.
- Owner drops req and reasserts on the same cycle it is released: it is treated as a new request and arbitrated normally from the updated ptr.
- Request deasserted before the grant appears: if req[i] falls in the cycle its gnt first appears, the grant still lasts 1 cycle, then releases.
- Outputs: gnt_valid = |gnt. gnt_idx is encoded from gnt. Both are registered alongside gnt.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- Defined:
  - A hold counter counts BUSY cycles, starting at 1 on the first cycle of the grant.
  - When the counter reaches MAX_HOLD, release is forced at the next edge exactly as a normal release (gnt<=0, ptr advances, IDLE), even if req[owner] is still 1.
  - The owner must re-compete; it is re-granted only if no other requester sits ahead of it in ptr order.
  - The counter clears on every release and on reset.
- Undefined: no counter logic; a grant is held indefinitely while req[owner]=1.

Decomposition:
- Package ring_arb_pkg holds:
  - the state typedef (IDLE, BUSY);
  - default constants N_DEF=4 and MAX_HOLD_DEF=8.
- Sub-module ring_ptr: N-bit one-hot ring register with async active-high reset to bit 0.
  - It has a load input (owner one-hot) plus an advance enable, and rotates left by 1 on load.
- The priority search is combinational inside ring_rr_arbiter.

Test Plan (N=4; "+k" means k edges later):
- Reset: rst=1 -> gnt=0000, ptr=0001, gnt_valid=0, gnt_idx=0. Assert rst mid-grant -> gnt=0000 before the next clk edge.
- Single request: req=0100 -> gnt=0100, gnt_idx=2 at +1. Drop req -> gnt=0000, ptr=1000 at +1.
- Fairness: req=1111 with each owner dropping req after 2 granted cycles, then reasserting -> grant order 0001, 0010, 0100, 1000, 0001, with one gnt=0000 cycle between each.
- Wrap-around: ptr=1000, req=0011 -> gnt=0001. After release, ptr=0010; with req=0011 still present -> next gnt=0010.
- No preemption: owner 0001 holds while req=1111 for 10 cycles -> gnt stays 0001 for all 10 cycles (macro undefined).
- Timeout (RR_TIMEOUT_EN, MAX_HOLD=4): req=0011 held constant -> gnt=0001 for 4 cycles, 0000 for 1, 0010 for 4, 0000 for 1, then 0001 again.
